// File: rtl/femto_bus_pkg.sv
// femto_bus_pkg: shared constants for the FemtoRV32 two-master bus arbiter.
//   ST_IDLE / ST_BUSY : arbiter FSM encodings
//   M0 / M1           : master ids (owner, last_grant)
//   FEMTO_WMASK_W     : byte write-mask width
package femto_bus_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int FEMTO_WMASK_W = 4;

endpackage

// File: rtl/femto_bus_req_latch.sv
// femto_bus_req_latch: holds one deferred request for a single master.
//   clk, reset      : clock, synchronous active-low reset
//   le              : capture cap_* and set pend
//   clr             : pending request has been issued, drop pend
//   cap_addr/wdata/wmask/read : live request fields from the master
//   addr/wdata/wmask/is_read  : captured request fields
//   pend            : a captured request is waiting for the slave
module femto_bus_req_latch
  import femto_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     le,
  input  logic                     clr,
  input  logic [ADDR_WIDTH-1:0]    cap_addr,
  input  logic [31:0]              cap_wdata,
  input  logic [FEMTO_WMASK_W-1:0] cap_wmask,
  input  logic                     cap_read,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [31:0]              wdata,
  output logic [FEMTO_WMASK_W-1:0] wmask,
  output logic                     is_read,
  output logic                     pend
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr    <= '0;
      wdata   <= '0;
      wmask   <= '0;
      is_read <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (le) begin
        addr    <= cap_addr;
        wdata   <= cap_wdata;
        wmask   <= cap_wmask;
        is_read <= cap_read;
        pend    <= 1'b1;
      end else if (clr) begin
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/femto_bus_arbiter.sv
// femto_bus_arbiter: shares one FemtoRV32 slave between M0 (core) and M1
// (DMA/debug). Uncontended requests pass straight through in the strobe
// cycle; a request that loses arbitration or arrives while the slave is
// busy is latched and replayed, with the master held busy meanwhile.
//   clk, reset                 : clock, synchronous active-low reset
//   mX_addr/wdata/wmask/rstrb  : master X request
//   mX_rdata/rbusy/wbusy       : master X response
//   s_addr/wdata/wmask/rstrb   : slave request
//   s_rdata/rbusy/wbusy        : slave response
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no slave access; arbitrate new + pending requests, issue
// ST_BUSY | owner's access in flight; wait for !s_rbusy & !s_wbusy
module femto_bus_arbiter
  import femto_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit RR_MODE    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    m0_addr,
  input  logic [31:0]              m0_wdata,
  input  logic [FEMTO_WMASK_W-1:0] m0_wmask,
  input  logic                     m0_rstrb,
  output logic [31:0]              m0_rdata,
  output logic                     m0_rbusy,
  output logic                     m0_wbusy,
  input  logic [ADDR_WIDTH-1:0]    m1_addr,
  input  logic [31:0]              m1_wdata,
  input  logic [FEMTO_WMASK_W-1:0] m1_wmask,
  input  logic                     m1_rstrb,
  output logic [31:0]              m1_rdata,
  output logic                     m1_rbusy,
  output logic                     m1_wbusy,
  output logic [ADDR_WIDTH-1:0]    s_addr,
  output logic [31:0]              s_wdata,
  output logic [FEMTO_WMASK_W-1:0] s_wmask,
  output logic                     s_rstrb,
  input  logic [31:0]              s_rdata,
  input  logic                     s_rbusy,
  input  logic                     s_wbusy
);

  logic [0:0]              state;
  logic                    owner;
  logic                    last_grant;
  logic [ADDR_WIDTH-1:0]   own_addr;
  logic [31:0]             own_wdata;
  logic                    own_is_read;

  logic [ADDR_WIDTH-1:0]    p0_addr, p1_addr;
  logic [31:0]              p0_wdata, p1_wdata;
  logic [FEMTO_WMASK_W-1:0] p0_wmask, p1_wmask;
  logic                     p0_read, p1_read, pend0, pend1;

  logic busy0, busy1, req0, req1, cand0, cand1, tie, win1, grant, done;
  logic le0, le1, clr0, clr1;
  logic own0, own1;

  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [31:0]              sel_wdata;
  logic [FEMTO_WMASK_W-1:0] sel_wmask;
  logic                     sel_read;

  // A strobe from a master that is still busy is dropped, which keeps
  // each master to a single outstanding request.
  assign busy0 = m0_rbusy | m0_wbusy;
  assign busy1 = m1_rbusy | m1_wbusy;
  assign req0  = (m0_rstrb | (|m0_wmask)) & ~busy0;
  assign req1  = (m1_rstrb | (|m1_wmask)) & ~busy1;

  // A master is either pending or presenting a new request, never both.
  assign cand0 = req0 | pend0;
  assign cand1 = req1 | pend1;
  assign tie   = cand0 & cand1;
  assign win1  = tie ? (RR_MODE ? (last_grant == M0) : 1'b0) : cand1;
  assign grant = (state == ST_IDLE) & (cand0 | cand1);
  assign done  = (state == ST_BUSY) & ~s_rbusy & ~s_wbusy;

  assign le0  = req0 & ((state == ST_BUSY) | (grant & win1));
  assign le1  = req1 & ((state == ST_BUSY) | (grant & ~win1));
  assign clr0 = grant & ~win1 & pend0;
  assign clr1 = grant & win1 & pend1;

  femto_bus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_latch0 (
    .clk(clk), .reset(reset), .le(le0), .clr(clr0),
    .cap_addr(m0_addr), .cap_wdata(m0_wdata), .cap_wmask(m0_wmask), .cap_read(m0_rstrb),
    .addr(p0_addr), .wdata(p0_wdata), .wmask(p0_wmask), .is_read(p0_read), .pend(pend0)
  );

  femto_bus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_latch1 (
    .clk(clk), .reset(reset), .le(le1), .clr(clr1),
    .cap_addr(m1_addr), .cap_wdata(m1_wdata), .cap_wmask(m1_wmask), .cap_read(m1_rstrb),
    .addr(p1_addr), .wdata(p1_wdata), .wmask(p1_wmask), .is_read(p1_read), .pend(pend1)
  );

  always_comb begin
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wmask = m0_wmask;
    sel_read  = m0_rstrb;
    if (win1) begin
      if (pend1) begin
        sel_addr = p1_addr; sel_wdata = p1_wdata; sel_wmask = p1_wmask; sel_read = p1_read;
      end else begin
        sel_addr = m1_addr; sel_wdata = m1_wdata; sel_wmask = m1_wmask; sel_read = m1_rstrb;
      end
    end else if (pend0) begin
      sel_addr = p0_addr; sel_wdata = p0_wdata; sel_wmask = p0_wmask; sel_read = p0_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= M0;
      last_grant  <= M1;
      own_addr    <= '0;
      own_wdata   <= '0;
      own_is_read <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state       <= ST_BUSY;
            owner       <= win1;
            own_addr    <= sel_addr;
            own_wdata   <= sel_wdata;
            own_is_read <= sel_read;
            // Round-robin memory only moves on real contention.
            if (tie) last_grant <= win1;
          end
        end
        default: begin
          if (done) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    s_rstrb = 1'b0;
    if (reset) begin
      if (state == ST_BUSY) begin
        s_addr  = own_addr;
        s_wdata = own_wdata;
      end else if (grant) begin
        s_addr  = sel_addr;
        s_wdata = sel_wdata;
        s_wmask = sel_wmask;
        s_rstrb = sel_read;
      end
    end
  end

  assign own0 = (state == ST_BUSY) & (owner == M0);
  assign own1 = (state == ST_BUSY) & (owner == M1);

  // Pending requests report busy unconditionally; the owner sees the
  // slave's own busy so an uncontended access behaves like a direct wire.
  assign m0_rbusy = reset & (pend0 ? p0_read  : (own0 & own_is_read  & s_rbusy));
  assign m0_wbusy = reset & (pend0 ? ~p0_read : (own0 & ~own_is_read & s_wbusy));
  assign m1_rbusy = reset & (pend1 ? p1_read  : (own1 & own_is_read  & s_rbusy));
  assign m1_wbusy = reset & (pend1 ? ~p1_read : (own1 & ~own_is_read & s_wbusy));

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  a_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset)
    !(m0_rstrb && (|m0_wmask)));
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset)
    !(m1_rstrb && (|m1_wmask)));
  a_m0_no_req_busy: assert property (@(posedge clk) disable iff (!reset)
    !((m0_rstrb || (|m0_wmask)) && busy0));
  a_m1_no_req_busy: assert property (@(posedge clk) disable iff (!reset)
    !((m1_rstrb || (|m1_wmask)) && busy1));

endmodule

// File: tb/tb_femto_bus_arbiter.sv
module tb_femto_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] s_rdata;
  logic        s_rbusy, s_wbusy;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb;
  logic [3:0]  s_wmask;

  logic [31:0] m0_rdata_f, m1_rdata_f, s_addr_f, s_wdata_f;
  logic        m0_rbusy_f, m0_wbusy_f, m1_rbusy_f, m1_wbusy_f, s_rstrb_f;
  logic [3:0]  s_wmask_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  femto_bus_arbiter #(.ADDR_WIDTH(32), .RR_MODE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
  );

  femto_bus_arbiter #(.ADDR_WIDTH(32), .RR_MODE(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata_f), .m0_rbusy(m0_rbusy_f), .m0_wbusy(m0_wbusy_f),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata_f), .m1_rbusy(m1_rbusy_f), .m1_wbusy(m1_wbusy_f),
    .s_addr(s_addr_f), .s_wdata(s_wdata_f), .s_wmask(s_wmask_f), .s_rstrb(s_rstrb_f),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the active edge, outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drv_m0(input logic rstrb, input logic [3:0] wmask,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_rstrb = rstrb; m0_wmask = wmask; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drv_m1(input logic rstrb, input logic [3:0] wmask,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m1_rstrb = rstrb; m1_wmask = wmask; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic masters_idle();
    drv_m0(1'b0, 4'h0, 32'h0, 32'h0);
    drv_m1(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    masters_idle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    s_rdata = 32'h1234_5678;
    s_rbusy = 1'b0;
    s_wbusy = 1'b0;
    masters_idle();

    // Reset state: a strobe during reset must not reach the slave.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h100, 32'h0);
    sample();
    check_val("rst_s_rstrb", {31'b0, s_rstrb}, 32'h0);
    check_val("rst_s_addr", s_addr, 32'h0);
    check_val("rst_m0_rbusy", {31'b0, m0_rbusy}, 32'h0);
    next_cycle();
    masters_idle();
    next_cycle();
    reset = 1'b1;
    sample();
    check_val("idle_s_wmask", {28'b0, s_wmask}, 32'h0);

    // 1: uncontended read passes through in the strobe cycle.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h100, 32'h0);
    sample();
    check_val("t1_s_rstrb", {31'b0, s_rstrb}, 32'h1);
    check_val("t1_s_addr", s_addr, 32'h100);
    next_cycle();
    masters_idle();
    sample();
    check_val("t1_m0_rbusy", {31'b0, m0_rbusy}, 32'h0);
    check_val("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    check_val("t1_s_rstrb_off", {31'b0, s_rstrb}, 32'h0);
    next_cycle();

    // 2: tie after reset, M0 wins; M1 write replayed two cycles after the strobe.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h104, 32'h0);
    drv_m1(1'b0, 4'hF, 32'h200, 32'hA5A5_0001);
    sample();
    check_val("t2_s_rstrb", {31'b0, s_rstrb}, 32'h1);
    check_val("t2_s_addr", s_addr, 32'h104);
    check_val("t2_s_wmask", {28'b0, s_wmask}, 32'h0);
    check_val("t2f_s_addr", s_addr_f, 32'h104);
    next_cycle();
    masters_idle();
    sample();
    check_val("t2_m1_wbusy_a", {31'b0, m1_wbusy}, 32'h1);
    check_val("t2_m0_rbusy", {31'b0, m0_rbusy}, 32'h0);
    check_val("t2_s_wmask_held", {28'b0, s_wmask}, 32'h0);
    next_cycle();
    sample();
    check_val("t2_s_wmask", {28'b0, s_wmask}, 32'hF);
    check_val("t2_s_addr_m1", s_addr, 32'h200);
    check_val("t2_s_wdata", s_wdata, 32'hA5A5_0001);
    check_val("t2_m1_wbusy_b", {31'b0, m1_wbusy}, 32'h1);
    next_cycle();
    sample();
    check_val("t2_m1_wbusy_done", {31'b0, m1_wbusy}, 32'h0);
    check_val("t2_s_wmask_off", {28'b0, s_wmask}, 32'h0);

    // 3: second tie back-to-back: round-robin gives M1, fixed priority gives M0.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h108, 32'h0);
    drv_m1(1'b0, 4'hF, 32'h204, 32'hA5A5_0002);
    sample();
    check_val("t3_rr_s_wmask", {28'b0, s_wmask}, 32'hF);
    check_val("t3_rr_s_addr", s_addr, 32'h204);
    check_val("t3_rr_s_rstrb", {31'b0, s_rstrb}, 32'h0);
    check_val("t3_fix_s_rstrb", {31'b0, s_rstrb_f}, 32'h1);
    check_val("t3_fix_s_addr", s_addr_f, 32'h108);
    next_cycle();
    masters_idle();
    sample();
    check_val("t3_rr_m0_rbusy", {31'b0, m0_rbusy}, 32'h1);
    check_val("t3_fix_m1_wbusy", {31'b0, m1_wbusy_f}, 32'h1);
    next_cycle();
    sample();
    check_val("t3_rr_s_rstrb2", {31'b0, s_rstrb}, 32'h1);
    check_val("t3_rr_s_addr2", s_addr, 32'h108);
    check_val("t3_fix_s_wmask2", {28'b0, s_wmask_f}, 32'hF);
    check_val("t3_fix_s_addr2", s_addr_f, 32'h204);
    next_cycle();
    sample();
    check_val("t3_rr_m0_rbusy_done", {31'b0, m0_rbusy}, 32'h0);
    check_val("t3_fix_m1_wbusy_done", {31'b0, m1_wbusy_f}, 32'h0);

    // 4: M1 write arrives while M0 read stalls 5 cycles.
    do_reset();
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h300, 32'h0);
    sample();
    check_val("t4_s_rstrb", {31'b0, s_rstrb}, 32'h1);
    next_cycle();
    masters_idle();
    s_rbusy = 1'b1;
    sample();
    check_val("t4_m0_rbusy", {31'b0, m0_rbusy}, 32'h1);
    next_cycle();
    drv_m1(1'b0, 4'h3, 32'h400, 32'hDEAD_BEEF);
    sample();
    check_val("t4_s_wmask_blocked", {28'b0, s_wmask}, 32'h0);
    check_val("t4_s_addr_hold", s_addr, 32'h300);
    next_cycle();
    masters_idle();
    sample();
    check_val("t4_m1_wbusy_a", {31'b0, m1_wbusy}, 32'h1);
    check_val("t4_s_wdata_hold", s_wdata, 32'h0);
    next_cycle();
    next_cycle();
    sample();
    check_val("t4_m1_wbusy_b", {31'b0, m1_wbusy}, 32'h1);
    next_cycle();
    s_rbusy = 1'b0;
    sample();
    check_val("t4_m0_rbusy_done", {31'b0, m0_rbusy}, 32'h0);
    check_val("t4_s_wmask_cmpl", {28'b0, s_wmask}, 32'h0);
    check_val("t4_m1_wbusy_c", {31'b0, m1_wbusy}, 32'h1);
    next_cycle();
    sample();
    check_val("t4_s_wmask", {28'b0, s_wmask}, 32'h3);
    check_val("t4_s_addr", s_addr, 32'h400);
    check_val("t4_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check_val("t4_m1_wbusy_d", {31'b0, m1_wbusy}, 32'h1);
    next_cycle();
    sample();
    check_val("t4_m1_wbusy_done", {31'b0, m1_wbusy}, 32'h0);
    check_val("t4_s_wmask_off", {28'b0, s_wmask}, 32'h0);

    // 5: reset while BUSY with M1 pending abandons everything.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h500, 32'h0);
    next_cycle();
    masters_idle();
    s_rbusy = 1'b1;
    drv_m1(1'b0, 4'hF, 32'h600, 32'h1111_2222);
    sample();
    check_val("t5_m0_rbusy", {31'b0, m0_rbusy}, 32'h1);
    next_cycle();
    masters_idle();
    reset = 1'b0;
    sample();
    check_val("t5_rst_m1_wbusy", {31'b0, m1_wbusy}, 32'h0);
    check_val("t5_rst_s_addr", s_addr, 32'h0);
    next_cycle();
    reset = 1'b1;
    sample();
    check_val("t5_s_addr", s_addr, 32'h0);
    check_val("t5_s_wdata", s_wdata, 32'h0);
    check_val("t5_s_wmask", {28'b0, s_wmask}, 32'h0);
    check_val("t5_s_rstrb", {31'b0, s_rstrb}, 32'h0);
    check_val("t5_m0_rbusy_clr", {31'b0, m0_rbusy}, 32'h0);
    check_val("t5_m1_wbusy_clr", {31'b0, m1_wbusy}, 32'h0);
    next_cycle();
    s_rbusy = 1'b0;
    sample();
    check_val("t5_no_replay", {28'b0, s_wmask}, 32'h0);

    // Completion-cycle request: both pending afterwards, round-robin picks M1 first.
    next_cycle();
    drv_m0(1'b1, 4'h0, 32'h700, 32'h0);
    drv_m1(1'b0, 4'hF, 32'h800, 32'h5555_AAAA);
    sample();
    check_val("b_s_addr_m0", s_addr, 32'h700);
    next_cycle();
    masters_idle();
    drv_m0(1'b1, 4'h0, 32'h704, 32'h0);
    sample();
    check_val("b_s_rstrb_cmpl", {31'b0, s_rstrb}, 32'h0);
    next_cycle();
    masters_idle();
    sample();
    check_val("b_s_wmask_m1", {28'b0, s_wmask}, 32'hF);
    check_val("b_s_addr_m1", s_addr, 32'h800);
    check_val("b_m0_rbusy_pend", {31'b0, m0_rbusy}, 32'h1);
    next_cycle();
    sample();
    check_val("b_m1_wbusy_done", {31'b0, m1_wbusy}, 32'h0);
    next_cycle();
    sample();
    check_val("b_s_rstrb_m0", {31'b0, s_rstrb}, 32'h1);
    check_val("b_s_addr_m0b", s_addr, 32'h704);
    next_cycle();
    sample();
    check_val("b_m0_rbusy_done", {31'b0, m0_rbusy}, 32'h0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
